// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between execute and writeback, one word-aligned req/gnt/rvalid access at a time.
// Latency: store done 2 cycles after accept, load done 3 (gnt/rvalid immediate), fault done 1; done_o pulses one cycle.
// Backpressure: ready_o is high only in IDLE; memory stalls via mem_gnt_i/mem_rvalid_i. Optional LSU_TIMEOUT_EN aborts stuck accesses.
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        illegal_q, misalign_q, bus_err_q;

  logic        is_ld_in, is_st_in, accept, ill_in, mis_in;
  logic        timeout_hit;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] st_data, load_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_ld_in = (opcode == OP_LOAD);
  assign is_st_in = (opcode == OP_STORE);
  assign accept   = (state == IDLE) && valid_i && (is_ld_in || is_st_in);
  // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
  assign ill_in   = is_ld_in ? (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                             : (funct3 >= 3'd3);
  assign mis_in   = ((funct3[1:0] == 2'd1) && addr_i[0]) ||
                    ((funct3[1:0] == 2'd2) && (addr_i[1:0] != 2'd0));
  assign off      = addr_q[1:0];

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;

  // Single cycle budget shared by REQ and WAIT, restarted on each REQ entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                to_cnt <= '0;
    else if (state != REQ && state_nxt == REQ) to_cnt <= '0;
    else if (state == REQ || state == WAIT)    to_cnt <= to_cnt + 1'b1;
  end

  // A gnt/rvalid in the limit cycle still completes normally.
  assign timeout_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1)) &&
                       ((state == REQ && !mem_gnt_i) || (state == WAIT && !mem_rvalid_i));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: faults skip the bus entirely; stores finish on gnt, loads on rvalid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (ill_in || mis_in) ? DONE : REQ;
      REQ:  if (mem_gnt_i)         state_nxt = is_load_q ? WAIT : DONE;
            else if (timeout_hit)  state_nxt = DONE;
      WAIT: if (mem_rvalid_i || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at accept, fault flags, and formatted load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q  <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      if (accept) begin
        is_load_q  <= is_ld_in;
        f3_q       <= funct3;
        addr_q     <= addr_i;
        wdata_q    <= wdata_i;
        illegal_q  <= ill_in;
        misalign_q <= mis_in && !ill_in;
        bus_err_q  <= 1'b0;
      end
      if (timeout_hit) bus_err_q <= 1'b1;
      if (state == WAIT && mem_rvalid_i) rdata_q <= load_fmt;
    end
  end

  // Byte enables and lane-replicated store data from the latched size/offset.
  always_comb begin
    be      = 4'b1111;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'd0: begin be = 4'b0001 << off; st_data = {4{wdata_q[7:0]}};  end
      2'd1: begin be = 4'b0011 << off; st_data = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;     st_data = wdata_q;            end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    byte_sel = mem_rdata_i[{off, 3'b000} +: 8];
    half_sel = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_fmt = mem_rdata_i;
    case (f3_q)
      3'd0:    load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_fmt = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_fmt = {24'd0, byte_sel};
      3'd5:    load_fmt = {16'd0, half_sel};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  assign ready_o     = (state == IDLE);
  assign done_o      = (state == DONE);
  assign illegal_o   = done_o && illegal_q;
  assign misalign_o  = done_o && misalign_q;
  assign bus_err_o   = done_o && bus_err_q;
  assign rdata_o     = rdata_q;
  // Bus outputs are only driven while a request is outstanding.
  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = mem_req_o && !is_load_q;
  assign mem_be_o    = mem_req_o ? be : 4'b0000;
  assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata_o = (mem_req_o && !is_load_q) ? st_data : 32'd0;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed vector table plus hand sequences for lsu_mem_if.
// Latency: checks done_o cycle relative to accept for each vector.
// Backpressure: gnt/rvalid delays come from the vector table.
module tb_lsu_mem_if;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
  logic        ready_o, done_o, misalign_o, illegal_o, bus_err_o;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 32'd0;

  lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .opcode(opcode), .funct3(funct3), .addr_i(addr_i), .wdata_i(wdata_i),
    .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, mrdata;
    int          gd, rd, done_cyc;
    logic        req;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, rdata;
    logic        mis, ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] mrdata, input int gd,
                     input int rd, input int done_cyc, input logic req, input logic [3:0] be,
                     input logic [31:0] maddr, input logic [31:0] mwdata,
                     input logic [31:0] rdata, input logic mis, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.gd = gd; v.rd = rd; v.done_cyc = done_cyc; v.req = req; v.be = be;
    v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata; v.mis = mis; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Apply one transaction starting in IDLE, #1 after a rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int req_n = 0;
    int gnt_cyc = -1;
    bit fin = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; opcode = v.op; funct3 = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    while (!fin && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      valid_i = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_A5A5;
      if (!v.req) begin
        chk({tag, "_noreq"}, {31'd0, mem_req_o}, 32'd0);
      end else if (mem_req_o) begin
        chk({tag, "_addr"}, mem_addr_o, v.maddr);
        chk({tag, "_be"},   {28'd0, mem_be_o}, {28'd0, v.be});
        chk({tag, "_we"},   {31'd0, mem_we_o}, {31'd0, v.op == ST});
        if (v.op == ST) chk({tag, "_wdata"}, mem_wdata_o, v.mwdata);
        if (req_n == v.gd) begin
          mem_gnt_i = 1'b1;
          gnt_cyc = cyc;
        end
        req_n++;
      end else if (gnt_cyc >= 0 && (cyc - gnt_cyc) == v.rd) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.mrdata;
      end
      if (done_o) begin
        fin = 1;
        chk({tag, "_done_cyc"}, cyc, v.done_cyc);
        chk({tag, "_mis"},   {31'd0, misalign_o}, {31'd0, v.mis});
        chk({tag, "_ill"},   {31'd0, illegal_o},  {31'd0, v.ill});
        chk({tag, "_berr"},  {31'd0, bus_err_o},  32'd0);
        chk({tag, "_rdata"}, rdata_o, v.rdata);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, fin}, 32'd1);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //   op  f3    addr          wdata         mrdata        gd rd done req be       maddr         mwdata        rdata        mis ill
    add(ST, 3'd0, 32'h0000_1003, 32'hA5A5_12F0, 32'h0,        0, 1, 2,  1, 4'b1000, 32'h0000_1000, 32'hF0F0_F0F0, 32'h0,        0, 0);
    add(LD, 3'd0, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 1, 3,  1, 4'b0010, 32'h0000_2000, 32'h0,        32'hFFFF_FF80, 0, 0);
    add(LD, 3'd4, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 1, 3,  1, 4'b0010, 32'h0000_2000, 32'h0,        32'h0000_0080, 0, 0);
    add(LD, 3'd1, 32'h0000_3002, 32'h0,        32'h7FFF_0000, 0, 1, 3,  1, 4'b1100, 32'h0000_3000, 32'h0,        32'h0000_7FFF, 0, 0);
    add(LD, 3'd2, 32'h0000_3002, 32'h0,        32'h0,        0, 1, 1,  0, 4'b0000, 32'h0,        32'h0,        32'h0000_7FFF, 1, 0);
    add(ST, 3'd3, 32'h0000_3000, 32'h1111_2222, 32'h0,        0, 1, 1,  0, 4'b0000, 32'h0,        32'h0,        32'h0000_7FFF, 0, 1);
    add(ST, 3'd1, 32'h0000_4002, 32'h1234_BEEF, 32'h0,        5, 1, 7,  1, 4'b1100, 32'h0000_4000, 32'hBEEF_BEEF, 32'h0000_7FFF, 0, 0);
    add(LD, 3'd5, 32'h0000_5000, 32'h0,        32'h1234_F00D, 2, 3, 7,  1, 4'b0011, 32'h0000_5000, 32'h0,        32'h0000_F00D, 0, 0);
    add(LD, 3'd1, 32'h0000_5002, 32'h0,        32'h8001_0000, 0, 1, 3,  1, 4'b1100, 32'h0000_5000, 32'h0,        32'hFFFF_8001, 0, 0);
    add(LD, 3'd2, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 1, 2, 5,  1, 4'b1111, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 0, 0);
    add(ST, 3'd2, 32'h0000_7004, 32'hCAFE_F00D, 32'h0,        0, 1, 2,  1, 4'b1111, 32'h0000_7004, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0);
    add(LD, 3'd1, 32'h0000_6001, 32'h0,        32'h0,        0, 1, 1,  0, 4'b0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 1, 0);
    add(LD, 3'd6, 32'h0000_6003, 32'h0,        32'h0,        0, 1, 1,  0, 4'b0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 0, 1);
    add(LD, 3'd0, 32'h0000_8003, 32'h0,        32'h7F00_0000, 0, 1, 3,  1, 4'b1000, 32'h0000_8000, 32'h0,        32'h0000_007F, 0, 0);
    add(ST, 3'd2, 32'h0000_7002, 32'h0,        32'h0,        0, 1, 1,  0, 4'b0000, 32'h0,        32'h0,        32'h0000_007F, 1, 0);

    // Reset state while reset is held.
    #12;
    chk("rst_ready", {31'd0, ready_o},   32'd1);
    chk("rst_done",  {31'd0, done_o},    32'd0);
    chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst_rdata", rdata_o,            32'd0);
    chk("rst_be",    {28'd0, mem_be_o},  32'd0);
    chk("rst_addr",  mem_addr_o,         32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Non-memory opcode is ignored.
    valid_i = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; addr_i = 32'h0000_1000;
    @(posedge clk); #1;
    valid_i = 1'b0; opcode = 7'd0;
    for (int c = 0; c < 4; c++) begin
      chk("oprr_done",  {31'd0, done_o},    32'd0);
      chk("oprr_ready", {31'd0, ready_o},   32'd1);
      chk("oprr_req",   {31'd0, mem_req_o}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    valid_i = 1'b1; opcode = LD; funct3 = 3'd2; addr_i = 32'h0000_A000;
    @(posedge clk); #1;
    valid_i = 1'b0; opcode = 7'd0;
    chk("rw_req", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    chk("rw_wait_ready", {31'd0, ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_ready", {31'd0, ready_o},   32'd1);
    chk("rw_rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rw_rst_done",  {31'd0, done_o},    32'd0);
    chk("rw_rst_rdata", rdata_o,            32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rw_late_done",  {31'd0, done_o}, 32'd0);
      chk("rw_late_rdata", rdata_o,         32'd0);
      @(posedge clk); #1;
    end

    // Grant never arrives.
    valid_i = 1'b1; opcode = LD; funct3 = 3'd2; addr_i = 32'h0000_9000;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      valid_i = 1'b0; opcode = 7'd0;
`ifdef LSU_TIMEOUT_EN
      chk($sformatf("to_req_c%0d", c),  {31'd0, mem_req_o}, {31'd0, c < 5});
      chk($sformatf("to_done_c%0d", c), {31'd0, done_o},    {31'd0, c == 5});
      chk($sformatf("to_berr_c%0d", c), {31'd0, bus_err_o}, {31'd0, c == 5});
      if (c == 5) chk("to_rdata", rdata_o, 32'd0);
`else
      chk($sformatf("hang_req_c%0d", c),  {31'd0, mem_req_o}, 32'd1);
      chk($sformatf("hang_done_c%0d", c), {31'd0, done_o},    32'd0);
`endif
    end
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("end_ready", {31'd0, ready_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit that consumes the ALU's effective-address result (`aluout`) for LOAD/STORE opcodes.
- Issues one word-aligned request at a time on a req/gnt/rvalid data-memory interface.
- Stores: byte-lane formatting and byte enables. Loads: lane extraction and sign/zero extension.
- Sits between execute and writeback; the core stalls while `ready_o` is low.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  request from execute stage
- ready_o  output  1  high only in IDLE; request accepted when valid_i && ready_o
- opcode  input  7  instruction opcode; only LOAD (7'b0000011) and STORE (7'b0100011) start a transaction
- funct3  input  3  access size/sign (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
- addr_i  input  32  effective address (ALU output)
- wdata_i  input  32  store data (rs2)
- done_o  output  1  one-cycle completion pulse
- rdata_o  output  32  formatted load result, valid with done_o, held until the next load completes
- misalign_o  output  1  with done_o: access misaligned, no memory access made
- illegal_o  output  1  with done_o: unsupported funct3, no memory access made
- bus_err_o  output  1  with done_o: timeout abort (0 without the optional feature)
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write
- mem_be_o  output  4  byte enables
- mem_addr_o  output  32  {addr_i[31:2],2'b00}
- mem_wdata_o  output  32  lane-replicated store data
- mem_gnt_i  input  1  request accepted this cycle
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  32  read data

Behaviour:
- Reset values: FSM=IDLE; ready_o=1; all other outputs 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- Accept and latch: in IDLE, on valid_i && ready_o with LOAD/STORE, latch opcode, funct3, addr_i, wdata_i. Other opcodes are ignored; FSM stays in IDLE with no pulse.
- Check at accept:
  - illegal: loads with funct3 3/6/7; stores with funct3 ≥3.
  - misaligned: H accesses with addr[0]=1; W accesses with addr[1:0]≠0.
  - Either fault goes IDLE→DONE with the matching flag; no mem_req_o. illegal takes priority over misaligned.
- Otherwise IDLE→REQ.
- REQ:
  - mem_req_o=1; mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o held stable until gnt.
  - On mem_gnt_i: store→DONE; load→WAIT.
  - mem_rvalid_i is ignored in REQ; memory returns rvalid ≥1 cycle after gnt.
- WAIT: on mem_rvalid_i, capture the formatted data into rdata_o, then →DONE.
- DONE: done_o=1 for exactly one cycle; flags valid this cycle only (0 otherwise); →IDLE.
- Byte enables: off=addr[1:0].
  - SB/LB/LBU: be=4'b0001<<off.
  - SH/LH/LHU: be=4'b0011<<off.
  - W: 4'b1111.
  - Loads drive mem_be_o with the same pattern.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load data:
  - LB/LBU: byte mem_rdata_i[8*off+:8], sign- or zero-extended to 32.
  - LH/LHU: half mem_rdata_i[8*off+:16], off∈{0,2}, extended.
  - LW: passthrough.
- Latency (min, gnt immediate):
  - store: accept cycle 0, req cycle 1, done cycle 2.
  - load with rvalid cycle 2: done cycle 3.
  - fault: done cycle 1.
- rdata_o is not updated by stores or faults.
- Asynchronous reset mid-transaction: return to IDLE, mem_req_o drops immediately, no done_o. A late rvalid after reset is ignored.
- mem_gnt_i and mem_rvalid_i outside REQ/WAIT: ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - 8+ bit counter cleared on entry to REQ, increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES without gnt/rvalid: drop mem_req_o, →DONE with bus_err_o=1; rdata_o unchanged.
  - A gnt/rvalid arriving in the same cycle as the limit wins (normal completion).
- Undefined: no counter, FSM waits indefinitely, bus_err_o tied 0.

Test Plan:
- SB addr 0x1003, wdata 0xA5A5_12F0, gnt same cycle as req -> mem_addr_o 0x1000, be 4'b1000, wdata 0xF0F0F0F0, we=1, done_o at cycle 2, no flags.
- LB addr 0x2001, rdata 0x0000_8000 (byte1=0x80), rvalid 1 cycle after gnt -> rdata_o 0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- LH addr 0x3002, rdata 0x7FFF_0000 -> be 4'b1100, rdata_o 0x0000_7FFF. LW addr 0x3002 -> misalign_o=1 with done_o at cycle 1, mem_req_o never asserted.
- Store funct3=3 -> illegal_o pulse, no request. Opcode OPRR with valid_i -> no done_o, FSM stays IDLE.
- Gnt withheld 5 cycles -> req/addr/be/wdata stable all 5 cycles. Reset asserted in WAIT -> outputs zero, ready_o=1, later rvalid ignored.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> bus_err_o and done_o together, 4 cycles after REQ entry. Without the macro -> FSM stays in REQ.
